// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU decode codes,
// FSM states and the EX/MEM result bundle.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam int MUL_STEPS = 4;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_NOP
  } alu_ctrl_e;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } mul_state_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        zero;
    logic [31:0] result;
    logic [31:0] br_target;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } exmem_t;

  function automatic alu_ctrl_e alu_ctrl(
    input logic [1:0] op,
    input logic [5:0] fn
  );
    alu_ctrl_e c;
    c = ALU_NOP;
    case (op)
      ALUOP_ADD, ALUOP_ADDI: c = ALU_ADD;
      ALUOP_SUB:             c = ALU_SUB;
      ALUOP_RTYPE: begin
        case (fn)
          FN_ADD:  c = ALU_ADD;
          FN_SUB:  c = ALU_SUB;
          FN_AND:  c = ALU_AND;
          FN_OR:   c = ALU_OR;
          FN_SLT:  c = ALU_SLT;
          FN_MUL:  c = ALU_MUL;
          default: c = ALU_NOP;
        endcase
      end
      default: c = ALU_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative 32x32 multiplier, low 32 bits, one 8-bit slice of b per cycle.
// Product is valid combinationally while done_o is high.
module mul_iter
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] product_o
);

  logic [31:0] a_q, b_q, acc_q;
  logic [1:0]  cnt_q;
  logic        busy_q;
  logic [4:0]  sh;
  logic [7:0]  slice;
  logic [31:0] pp, step_sum;

  assign sh       = {cnt_q, 3'b000};
  assign slice    = b_q[sh +: 8];
  assign pp       = a_q * {24'd0, slice};
  assign step_sum = acc_q + (pp << sh);

  assign done_o    = busy_q && (cnt_q == 2'(MUL_STEPS - 1));
  assign product_o = step_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= step_sum;
      if (done_o) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative multiply and the
// EX/MEM pipeline register.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        Branch_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegDst_i,
  input  logic        ALUSrc_i,
  input  logic [1:0]  ALUOp_i,
  input  logic [31:0] Adder_i,
  input  logic [31:0] RSdata_i,
  input  logic [31:0] RTdata_i,
  input  logic [31:0] Sign_Extend_i,
  input  logic [4:0]  RSaddr_i,
  input  logic [4:0]  data1_i,
  input  logic [4:0]  data2_i,
  input  logic        EXMEM_RegWrite_i,
  input  logic [4:0]  EXMEM_RD_i,
  input  logic [31:0] EXMEM_data_i,
  input  logic        MEMWB_RegWrite_i,
  input  logic [4:0]  MEMWB_RD_i,
  input  logic [31:0] MEMWB_data_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic        Branch_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Zero_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] BranchTarget_o,
  output logic [31:0] WriteData_o,
  output logic [4:0]  RD_o,
  output logic        stall_o
);

  logic [31:0] op_a, fwd_b, op_b, alu_res;
  logic [31:0] mul_prod, rt_q, res_sel, wd_sel;
  logic        mul_start, mul_done, capture, stall;
  alu_ctrl_e   ctrl;
  mul_state_e  state_q, state_d;
  exmem_t      out_q, out_d;

  // EX/MEM hazard wins over MEM/WB; register 0 never forwards
  always_comb begin
    op_a = RSdata_i;
    if (EXMEM_RegWrite_i && EXMEM_RD_i != '0 && EXMEM_RD_i == RSaddr_i)
      op_a = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && MEMWB_RD_i != '0 && MEMWB_RD_i == RSaddr_i)
      op_a = MEMWB_data_i;
  end

  always_comb begin
    fwd_b = RTdata_i;
    if (EXMEM_RegWrite_i && EXMEM_RD_i != '0 && EXMEM_RD_i == data1_i)
      fwd_b = EXMEM_data_i;
    else if (MEMWB_RegWrite_i && MEMWB_RD_i != '0 && MEMWB_RD_i == data1_i)
      fwd_b = MEMWB_data_i;
  end

  assign op_b = ALUSrc_i ? Sign_Extend_i : fwd_b;
  assign ctrl = alu_ctrl(ALUOp_i, Sign_Extend_i[5:0]);

  always_comb begin
    alu_res = '0;
    case (ctrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mul_start = 1'b0;
    capture   = 1'b0;
    if (rst_i || flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (valid_i && ctrl == ALU_MUL) begin
            stall     = 1'b1;
            mul_start = 1'b1;
            state_d   = S_MUL;
          end else begin
            capture = valid_i;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            capture = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign stall_o = stall;

  // A finishing mul uses operands captured at acceptance
  assign res_sel = (state_q == S_MUL) ? mul_prod : alu_res;
  assign wd_sel  = (state_q == S_MUL) ? rt_q : fwd_b;

  always_comb begin
    out_d = '0;
    if (capture) begin
      out_d.valid      = 1'b1;
      out_d.reg_write  = RegWrite_i;
      out_d.mem_to_reg = MemtoReg_i;
      out_d.branch     = Branch_i;
      out_d.mem_read   = MemRead_i;
      out_d.mem_write  = MemWrite_i;
      out_d.zero       = (res_sel == '0);
      out_d.result     = res_sel;
      out_d.br_target  = Adder_i + (Sign_Extend_i << 2);
      out_d.wdata      = wd_sel;
      out_d.rd         = RegDst_i ? data2_i : data1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (flush_i)
        rt_q <= '0;
      else if (mul_start)
        rt_q <= fwd_b;
    end
  end

  mul_iter u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (flush_i),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign valid_o        = out_q.valid;
  assign RegWrite_o     = out_q.reg_write;
  assign MemtoReg_o     = out_q.mem_to_reg;
  assign Branch_o       = out_q.branch;
  assign MemRead_o      = out_q.mem_read;
  assign MemWrite_o     = out_q.mem_write;
  assign Zero_o         = out_q.zero;
  assign ALUResult_o    = out_q.result;
  assign BranchTarget_o = out_q.br_target;
  assign WriteData_o    = out_q.wdata;
  assign RD_o           = out_q.rd;

endmodule
